uart_rx: RTL and testbench

- Serial-to-parallel UART receiver: 8N1 framing, LSB first, idle-high line. This is the receive-side counterpart of the team's uart_tx.
- Consumes the serial line driven by a uart_tx (on-chip loopback or external pin).
- Presents each received byte with a one-cycle valid pulse.
- Reports framing errors so the downstream command parser can discard bad bytes.

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
// Two-flop input synchroniser feeding a mid-bit sampling FSM. Each byte is
// presented with a one-cycle valid pulse. A low stop bit is reported with a
// one-cycle frame-error pulse, and the FSM then parks until the line returns high.
module uart_rx #(
    parameter int CLK_RATE      = 100_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int NCLKS_PER_BIT = CLK_RATE / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx_serial,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_busy,
    output logic       o_frame_err
);

    localparam int CW = $clog2(NCLKS_PER_BIT);
    localparam logic [CW-1:0] HALF     = CW'((NCLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE,
        S_BREAK
    } state_e;

    state_e        state_q,     state_d;
    logic          rx_meta_q,   rx_meta_d;
    logic          rx_s_q,      rx_s_d;
    logic [CW-1:0] clk_count_q, clk_count_d;
    logic [2:0]    bit_idx_q,   bit_idx_d;
    logic [7:0]    shift_q,     shift_d;
    logic [7:0]    data_q,      data_d;
    logic          valid_q,     valid_d;
    logic          err_q,       err_d;
    logic          busy_q,      busy_d;

    // Next-state logic: synchroniser stages, bit timing, framing and output pulses
    always_comb begin
        state_d     = state_q;
        rx_meta_d   = i_rx_serial;
        rx_s_d      = rx_meta_q;
        clk_count_d = clk_count_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_count_d = '0;
                bit_idx_d   = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (clk_count_q == HALF) begin
                    clk_count_d = '0;
                    // A line that is already high again at mid-start was a glitch
                    state_d     = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end

            S_DATA: begin
                if (clk_count_q == LAST_CNT) begin
                    clk_count_d        = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end

            S_STOP: begin
                if (clk_count_q == LAST_CNT) begin
                    clk_count_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end

            // The registered pulse flops double as the pending flags while in DONE
            S_DONE: begin
                state_d = err_q ? S_BREAK : S_IDLE;
            end

            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            clk_count_q <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            clk_count_q <= clk_count_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = err_q;
    assign o_rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench-side 8N1 transmitter drives uart_rx (16 clocks per bit).
// Expected pulses are queued as each stop bit is driven and popped by a monitor.
module tb_uart_rx;

    localparam int NCLK = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(
        .CLK_RATE     (NCLK * 9600),
        .BAUD_RATE    (9600),
        .NCLKS_PER_BIT(NCLK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_serial(rx),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_rx_busy  (rx_busy),
        .o_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        is_err;
        logic [7:0]  data;
        int unsigned stop_cyc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_data;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        vecs[8];
    int unsigned n_pulses       = 0;
    int unsigned last_valid_cyc = 0;
    int unsigned prev_valid_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Drives start, 8 data bits and the stop bit; the line is left at the stop level
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (NCLK) tick();
        for (int unsigned i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (NCLK) tick();
        end
        rx = stop;
        sb_q.push_back('{is_err: ~stop, data: d, stop_cyc: cyc});
        repeat (NCLK) tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check({"drain_", name}, sb_q.size(), 0);
    endtask

    // Scoreboard monitor: every valid / error pulse must match the queue head
    always @(negedge clk) begin
        if (!rst && (rx_valid || frame_err)) begin
            n_pulses++;
            check("valid_err_exclusive", {31'd0, rx_valid & frame_err}, 0);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b at cycle %0d, expected no pulse",
                         rx_valid, frame_err, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind_err", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                if (!mon_e.is_err) check("pulse_data", {24'd0, rx_data}, {24'd0, mon_e.data});
                check("pulse_latency", cyc - mon_e.stop_cyc, 11);
            end
            if (rx_valid) begin
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish by cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic        seen_busy;
        int unsigned n0;
        logic [7:0]  held;

        vecs = '{
            '{8'hA5, 1'b1, 4, 8'hA5},
            '{8'h00, 1'b1, 0, 8'h00},
            '{8'h7E, 1'b1, 2, 8'h7E},
            '{8'hFF, 1'b1, 4, 8'hFF},
            '{8'h3C, 1'b1, 4, 8'h3C},
            '{8'hC3, 1'b0, 8, 8'h3C},
            '{8'h81, 1'b1, 4, 8'h81},
            '{8'h5A, 1'b1, 3, 8'h5A}
        };

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) tick();
        check("reset_data",  {24'd0, rx_data}, 0);
        check("reset_valid", {31'd0, rx_valid}, 0);
        check("reset_err",   {31'd0, frame_err}, 0);
        check("reset_busy",  {31'd0, rx_busy}, 0);
        rst = 1'b0;
        tick();

        // Short low glitch: busy blips, nothing is received
        seen_busy = 1'b0;
        rx = 1'b0;
        repeat (5) begin tick(); seen_busy |= rx_busy; end
        rx = 1'b1;
        repeat (30) begin tick(); seen_busy |= rx_busy; end
        check("glitch_busy_seen", {31'd0, seen_busy}, 1);
        check("glitch_busy_idle", {31'd0, rx_busy}, 0);
        check("glitch_data",      {24'd0, rx_data}, 0);
        check("glitch_pulses",    n_pulses, 0);

        // Table of frames (includes the loopback bytes 00, 7E, FF, 3C)
        for (int unsigned i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            idle(vecs[i].gap);
            drain("vec");
            check("vec_data", {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
        end

        // Framing error followed by a held-low line
        idle(4);
        n0   = n_pulses;
        held = rx_data;
        send_frame(8'h3C, 1'b0);
        repeat (40) tick();
        drain("break");
        check("break_busy_held", {31'd0, rx_busy}, 1);
        check("break_data_held", {24'd0, rx_data}, {24'd0, held});
        rx = 1'b1;
        repeat (6) tick();
        check("break_busy_released", {31'd0, rx_busy}, 0);
        check("break_pulse_count", n_pulses - n0, 1);

        // Back-to-back frames with no idle gap
        idle(4);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        drain("b2b");
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 160);
        check("b2b_data", {24'd0, rx_data}, 8'hFF);

        // Reset during data bit 4 of 0x55
        idle(4);
        n0 = n_pulses;
        rx = 1'b0;
        repeat (NCLK) tick();
        for (int unsigned i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            repeat (NCLK) tick();
        end
        rx = 1'b1;
        repeat (NCLK / 2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'd0, rx_busy}, 0);
        check("midrst_data", {24'd0, rx_data}, 0);
        idle(20);
        check("midrst_no_pulse", n_pulses - n0, 0);
        send_frame(8'h81, 1'b1);
        idle(4);
        drain("after_rst");
        check("after_rst_data", {24'd0, rx_data}, 8'h81);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
